// File: rtl/ser_to_para_block.sv
// Serial-to-parallel receiver: rebuilds LSB-first bytes and packs NUM_BYTES of them into a held AES block.
// Optional STRICT_FRAMING_EN: a byte is accepted only when done_in accompanies bit 7.
module ser_to_para_block #(
    parameter int NUM_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic                   enable,
    input  logic                   DataIN,
    input  logic                   done_in,
    input  logic                   flush,
    input  logic                   block_ack,
    output logic [7:0]             ByteOUT,
    output logic                   byte_valid,
    output logic [8*NUM_BYTES-1:0] BlockOUT,
    output logic                   block_valid,
    output logic                   sync_err,
    output logic                   overrun,
    output logic                   slot_state_dbg
);

    localparam int CW = $clog2(NUM_BYTES);
    localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_BYTES - 1);

    // Output slot handshake: block_valid is a level, held until block_ack
    // samples high on a rising edge. An ack landing on the same edge as a new
    // block completion replaces the held block with no gap in block_valid.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    slot_state_t     slot_state, slot_state_nxt;
    logic [7:0]      shreg;
    logic [2:0]      bit_cnt;
    logic [CW-1:0]   byte_cnt;
    logic [7:0]      asm_buf [NUM_BYTES];

    logic                   capture;
    logic                   at_last_bit;
    logic                   byte_done;
    logic                   frame_err;
    logic                   block_done;
    logic                   load_block;
    logic                   drop_block;
    logic [7:0]             new_byte;
    logic [8*NUM_BYTES-1:0] asm_full;

    // flush outranks a bit arriving on the same edge, so it masks all capture
    always_comb begin
        capture     = enable & ~flush;
        at_last_bit = (bit_cnt == 3'd7);
`ifdef STRICT_FRAMING_EN
        byte_done   = capture & at_last_bit & done_in;
        frame_err   = capture & (done_in ^ at_last_bit);
`else
        byte_done   = capture & at_last_bit;
        frame_err   = capture & done_in & ~at_last_bit;
`endif
        new_byte    = {DataIN, shreg[6:0]};
        block_done  = byte_done & (byte_cnt == LAST_SLOT);
        load_block  = block_done & ((slot_state == SLOT_EMPTY) | block_ack);
        drop_block  = block_done & (slot_state == SLOT_FULL) & ~block_ack;
    end

    // Block as it will look once the incoming byte lands in its slot
    always_comb begin
        asm_full = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (k == int'(byte_cnt)) begin
                asm_full[8*k +: 8] = new_byte;
            end else begin
                asm_full[8*k +: 8] = asm_buf[k];
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            for (int k = 0; k < NUM_BYTES; k++) begin
                asm_buf[k] <= '0;
            end
        end else if (flush) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else if (enable) begin
            if (frame_err) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else begin
                shreg[bit_cnt] <= DataIN;
                bit_cnt        <= bit_cnt + 3'd1;
                if (byte_done) begin
                    asm_buf[byte_cnt] <= new_byte;
                    byte_cnt          <= block_done ? '0 : byte_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            ByteOUT    <= '0;
            byte_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            byte_valid <= byte_done;
            sync_err   <= frame_err;
            if (byte_done) begin
                ByteOUT <= new_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            slot_state <= SLOT_EMPTY;
        end else begin
            slot_state <= slot_state_nxt;
        end
    end

    always_comb begin
        slot_state_nxt = slot_state;
        case (slot_state)
            SLOT_EMPTY: if (block_done) slot_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (block_ack && !block_done) slot_state_nxt = SLOT_EMPTY;
            default:    slot_state_nxt = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            BlockOUT <= '0;
            overrun  <= 1'b0;
        end else begin
            if (load_block) begin
                BlockOUT <= asm_full;
            end
            if (drop_block) begin
                overrun <= 1'b1;
            end
        end
    end

    assign block_valid    = (slot_state == SLOT_FULL);
    assign slot_state_dbg = slot_state;

endmodule

// File: tb/tb_ser_to_para_block.sv
// Directed bench for ser_to_para_block: byte/block assembly, overrun, ack overlap, resync, reset/flush, enable gaps.
module tb_ser_to_para_block;

    localparam int NB = 16;

    logic          clk;
    logic          RST;
    logic          enable;
    logic          DataIN;
    logic          done_in;
    logic          flush;
    logic          block_ack;
    logic [7:0]    ByteOUT;
    logic          byte_valid;
    logic [8*NB-1:0] BlockOUT;
    logic          block_valid;
    logic          sync_err;
    logic          overrun;
    logic          slot_state_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    ser_to_para_block #(.NUM_BYTES(NB)) dut (
        .clk           (clk),
        .RST           (RST),
        .enable        (enable),
        .DataIN        (DataIN),
        .done_in       (done_in),
        .flush         (flush),
        .block_ack     (block_ack),
        .ByteOUT       (ByteOUT),
        .byte_valid    (byte_valid),
        .BlockOUT      (BlockOUT),
        .block_valid   (block_valid),
        .sync_err      (sync_err),
        .overrun       (overrun),
        .slot_state_dbg(slot_state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Block whose byte k is base+k
    function automatic logic [127:0] blk_seq(input logic [7:0] base);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < NB; k++) r[8*k +: 8] = base + 8'(k);
        return r;
    endfunction

    // Drivers
    task automatic send_bit(input logic b, input logic d, input logic ack);
        @(negedge clk);
        enable = 1'b1; DataIN = b; done_in = d; block_ack = ack;
        @(posedge clk); #1;
        enable = 1'b0; DataIN = 1'b0; done_in = 1'b0; block_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        block_ack = 1'b1;
        @(posedge clk); #1;
        block_ack = 1'b0;
    endtask

    // Scoreboard: bytes expected to be accepted are queued, popped on byte_valid
    task automatic send_byte(input logic [7:0] b, input logic done_last, input logic ack_last,
                             input logic accept);
        logic [7:0] e;
        if (accept) exp_q.push_back(b);
        for (int i = 0; i < 8; i++) send_bit(b[i], (i == 7) ? done_last : 1'b0, (i == 7) ? ack_last : 1'b0);
        check("byte_valid_on_byte", {127'd0, byte_valid}, {127'd0, accept});
        if (accept) begin
            if (exp_q.size() == 0) begin
                check("exp_q_underflow", 128'd1, 128'd0);
            end else begin
                e = exp_q.pop_front();
                check("byte_out", {120'd0, ByteOUT}, {120'd0, e});
            end
        end
    endtask

    task automatic send_block(input logic [7:0] base, input logic ack_last);
        for (int k = 0; k < NB; k++) send_byte(base + 8'(k), 1'b1, (k == NB - 1) ? ack_last : 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 RST = 1'b0;
        @(negedge clk);
        RST = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_byteout"},     {120'd0, ByteOUT}, 128'd0);
        check({tag, "_byte_valid"},  {127'd0, byte_valid}, 128'd0);
        check({tag, "_blockout"},    BlockOUT, 128'd0);
        check({tag, "_block_valid"}, {127'd0, block_valid}, 128'd0);
        check({tag, "_sync_err"},    {127'd0, sync_err}, 128'd0);
        check({tag, "_overrun"},     {127'd0, overrun}, 128'd0);
    endtask

    initial begin
        logic [127:0] exp_blk;
        logic [7:0]   gap_byte;
        RST = 1'b0; enable = 1'b0; DataIN = 1'b0; done_in = 1'b0; flush = 1'b0; block_ack = 1'b0;
        idle(2);
        check_all_zero("reset");
        @(negedge clk) RST = 1'b1;

        // Single byte A5
        send_byte(8'hA5, 1'b1, 1'b0, 1'b1);
        check("a5_value", {120'd0, ByteOUT}, {120'd0, 8'hA5});
        idle(1);
        check("a5_pulse_width", {127'd0, byte_valid}, 128'd0);

        // Full block 00..0F, then hold without ack
        do_reset();
        for (int k = 0; k < NB - 1; k++) send_byte(8'(k), 1'b1, 1'b0, 1'b1);
        check("blk0_not_yet_valid", {127'd0, block_valid}, 128'd0);
        send_byte(8'h0F, 1'b1, 1'b0, 1'b1);
        check("blk0_valid", {127'd0, block_valid}, 128'd1);
        check("blk0_data", BlockOUT, 128'h0F0E0D0C0B0A09080706050403020100);
        idle(5);
        check("blk0_hold_valid", {127'd0, block_valid}, 128'd1);
        check("blk0_hold_data", BlockOUT, 128'h0F0E0D0C0B0A09080706050403020100);

        // Overrun: second block while first unacked
        send_block(8'h10, 1'b0);
        check("ovr_flag", {127'd0, overrun}, 128'd1);
        check("ovr_data_kept", BlockOUT, blk_seq(8'h00));
        check("ovr_valid_kept", {127'd0, block_valid}, 128'd1);
        pulse_ack();
        check("ack_clears_valid", {127'd0, block_valid}, 128'd0);
        check("ack_keeps_data", BlockOUT, blk_seq(8'h00));
        pulse_ack();
        check("ack_when_empty", {127'd0, block_valid}, 128'd0);
        send_block(8'h20, 1'b0);
        check("blk2_valid", {127'd0, block_valid}, 128'd1);
        check("blk2_data", BlockOUT, blk_seq(8'h20));
        send_block(8'h30, 1'b1);
        check("ack_overlap_valid", {127'd0, block_valid}, 128'd1);
        check("ack_overlap_data", BlockOUT, blk_seq(8'h30));
        idle(1);
        check("ack_overlap_hold", {127'd0, block_valid}, 128'd1);
        check("ovr_sticky", {127'd0, overrun}, 128'd1);

        // Resync: 3 bits then done_in on the 4th
        do_reset();
        send_byte(8'h11, 1'b1, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        check("resync_err", {127'd0, sync_err}, 128'd1);
        check("resync_no_byte", {127'd0, byte_valid}, 128'd0);
        idle(1);
        check("resync_err_pulse", {127'd0, sync_err}, 128'd0);
        send_byte(8'h3C, 1'b1, 1'b0, 1'b1);
        check("resync_3c", {120'd0, ByteOUT}, {120'd0, 8'h3C});
        for (int k = 2; k < NB; k++) send_byte(8'h20 + 8'(k - 2), 1'b1, 1'b0, 1'b1);
        exp_blk = '0;
        exp_blk[7:0]  = 8'h11;
        exp_blk[15:8] = 8'h3C;
        for (int k = 2; k < NB; k++) exp_blk[8*k +: 8] = 8'h20 + 8'(k - 2);
        check("resync_block", BlockOUT, exp_blk);
        check("resync_block_valid", {127'd0, block_valid}, 128'd1);

        // Async reset after 5 bytes and 4 bits
        for (int k = 0; k < 5; k++) send_byte(8'hE0 + 8'(k), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
        #2 RST = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk) RST = 1'b1;
        send_block(8'h40, 1'b0);
        check("post_reset_block", BlockOUT, blk_seq(8'h40));
        check("post_reset_valid", {127'd0, block_valid}, 128'd1);

        // Flush mid-block with a simultaneous bit; held block untouched
        for (int k = 0; k < 5; k++) send_byte(8'h50 + 8'(k), 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        flush = 1'b1; enable = 1'b1; DataIN = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; enable = 1'b0; DataIN = 1'b0;
        check("flush_keeps_valid", {127'd0, block_valid}, 128'd1);
        check("flush_keeps_data", BlockOUT, blk_seq(8'h40));
        check("flush_no_overrun", {127'd0, overrun}, 128'd0);
        check("flush_no_byte", {127'd0, byte_valid}, 128'd0);
        pulse_ack();
        send_block(8'h60, 1'b0);
        check("post_flush_block", BlockOUT, blk_seq(8'h60));
        check("post_flush_overrun", {127'd0, overrun}, 128'd0);

        // Enable gaps inside 8'h81
        gap_byte = 8'h81;
        for (int i = 0; i < 8; i++) begin
            send_bit(gap_byte[i], (i == 7), 1'b0);
            if (i < 7) idle(3);
        end
        check("gap_valid", {127'd0, byte_valid}, 128'd1);
        check("gap_value", {120'd0, ByteOUT}, {120'd0, 8'h81});

        // Bit 7 without done_in
`ifdef STRICT_FRAMING_EN
        send_byte(8'h5A, 1'b0, 1'b0, 1'b0);
        check("strict_sync_err", {127'd0, sync_err}, 128'd1);
`else
        send_byte(8'h5A, 1'b0, 1'b0, 1'b1);
        check("loose_no_sync_err", {127'd0, sync_err}, 128'd0);
`endif

        idle(2);
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
